// File: rtl/pwm_motor_pkg.sv
// Shared constants and types for the DC-motor PWM link (generator and decoder).
package pwm_motor_pkg;

    localparam int unsigned PERIOD_TICKS = 2801;
    localparam int unsigned BASE_TICKS   = 500;
    localparam int unsigned STEP_TICKS   = 300;
    localparam int unsigned TOL_TICKS    = 150;

    typedef logic [2:0] speed_code_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } dec_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for the asynchronous PWM line plus one edge-detect flop.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic rise_c_o,
    output logic level_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c_o = s2_q & ~s3_q;
    assign level_o  = s2_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of the motor PWM line and recovers the 3-bit speed code.
module pwm_duty_decoder #(
    parameter int unsigned PRESCALE_LOG2 = 8,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned PERIOD_TICKS  = pwm_motor_pkg::PERIOD_TICKS,
    parameter int unsigned BASE_TICKS    = pwm_motor_pkg::BASE_TICKS,
    parameter int unsigned STEP_TICKS    = pwm_motor_pkg::STEP_TICKS,
    parameter int unsigned TOL_TICKS     = pwm_motor_pkg::TOL_TICKS,
    parameter int unsigned TIMEOUT_TICKS = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [2:0]       speed_code,
    output logic             code_valid,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] period_ticks,
    output logic             range_err,
    output logic             period_err,
    output logic             stalled,
    output logic             pwm_level
);

    import pwm_motor_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HIGH_MIN = CNT_W'(BASE_TICKS - TOL_TICKS);
    localparam logic [CNT_W-1:0] HIGH_MAX = CNT_W'(BASE_TICKS + 7 * STEP_TICKS + TOL_TICKS);
    localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(PERIOD_TICKS - TOL_TICKS);
    localparam logic [CNT_W-1:0] PER_MAX  = CNT_W'(PERIOD_TICKS + TOL_TICKS);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_TICKS);

    // Code = number of mid-step thresholds the high time reaches.
    function automatic speed_code_t decode_code(input logic [CNT_W-1:0] high);
        speed_code_t code;
        code = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            if (high >= CNT_W'(BASE_TICKS + STEP_TICKS / 2 + j * STEP_TICKS)) begin
                code = code + 3'd1;
            end
        end
        return code;
    endfunction

    logic rise_c;
    logic level;

    pwm_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_i    (pwm_in),
        .rise_c_o (rise_c),
        .level_o  (level)
    );

    logic [PRESCALE_LOG2-1:0] pre_q;
    logic                     tick_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRESCALE_LOG2'(1);
        end
    end

    assign tick_c = &pre_q;

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    speed_code_t      speed_q, speed_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             rerr_q, rerr_d;
    logic             perr_q, perr_d;
    logic             stalled_q, stalled_d;

    logic [CNT_W-1:0] per_inc_c;
    logic [CNT_W-1:0] hi_inc_c;
    logic             range_bad_c;
    logic             period_bad_c;

    // Saturating tick counters; per_inc_c doubles as the closing period length.
    always_comb begin
        per_inc_c = per_cnt_q;
        if (tick_c && per_cnt_q != CNT_MAX) begin
            per_inc_c = per_cnt_q + CNT_W'(1);
        end
        hi_inc_c = hi_cnt_q;
        if (tick_c && level && hi_cnt_q != CNT_MAX) begin
            hi_inc_c = hi_cnt_q + CNT_W'(1);
        end
        range_bad_c  = (hi_cnt_q < HIGH_MIN) || (hi_cnt_q > HIGH_MAX);
        period_bad_c = (per_inc_c < PER_MIN) || (per_inc_c > PER_MAX);
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_inc_c;
        hi_cnt_d  = hi_inc_c;
        speed_d   = speed_q;
        valid_d   = 1'b0;
        high_d    = high_q;
        period_d  = period_q;
        rerr_d    = rerr_q;
        perr_d    = perr_q;
        stalled_d = stalled_q;

        if (rise_c) begin
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            stalled_d = 1'b0;
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM, MEASURE: begin
                    state_d  = MEASURE;
                    valid_d  = 1'b1;
                    high_d   = hi_cnt_q;
                    period_d = per_inc_c;
                    rerr_d   = range_bad_c;
                    perr_d   = period_bad_c;
                    if (!range_bad_c) begin
                        speed_d = decode_code(hi_cnt_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (per_cnt_q == TIMEOUT) begin
            // Edgeless line: either 0% or 100% duty, pwm_level tells which.
            stalled_d = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            speed_q   <= '0;
            valid_q   <= 1'b0;
            high_q    <= '0;
            period_q  <= '0;
            rerr_q    <= 1'b0;
            perr_q    <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            speed_q   <= speed_d;
            valid_q   <= valid_d;
            high_q    <= high_d;
            period_q  <= period_d;
            rerr_q    <= rerr_d;
            perr_q    <= perr_d;
            stalled_q <= stalled_d;
        end
    end

    assign speed_code   = speed_q;
    assign code_valid   = valid_q;
    assign high_ticks   = high_q;
    assign period_ticks = period_q;
    assign range_err    = rerr_q;
    assign period_err   = perr_q;
    assign stalled      = stalled_q;
    assign pwm_level    = level;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder; prescaler shortened to 2 clk per tick to keep runtime small.
module tb_pwm_duty_decoder;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned TCLK  = 2;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             pwm_in = 1'b0;
    logic [2:0]       speed_code;
    logic             code_valid;
    logic [CNT_W-1:0] high_ticks;
    logic [CNT_W-1:0] period_ticks;
    logic             range_err;
    logic             period_err;
    logic             stalled;
    logic             pwm_level;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    pwm_duty_decoder #(
        .PRESCALE_LOG2 (1),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .speed_code   (speed_code),
        .code_valid   (code_valid),
        .high_ticks   (high_ticks),
        .period_ticks (period_ticks),
        .range_err    (range_err),
        .period_err   (period_err),
        .stalled      (stalled),
        .pwm_level    (pwm_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (code_valid) n_valid <= n_valid + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".speed"},   32'(speed_code),   0);
        check({tag, ".valid"},   32'(code_valid),   0);
        check({tag, ".high"},    32'(high_ticks),   0);
        check({tag, ".period"},  32'(period_ticks), 0);
        check({tag, ".rerr"},    32'(range_err),    0);
        check({tag, ".perr"},    32'(period_err),   0);
        check({tag, ".stalled"}, 32'(stalled),      0);
        check({tag, ".level"},   32'(pwm_level),    0);
    endtask

    // Rising edge that closes the previous period; results checked 4 clk later.
    task automatic close_chk(input string tag, input bit ev, input int code, input int hi,
                             input int per, input int rerr, input int perr);
        int v0;
        v0 = n_valid;
        pwm_in = 1'b1;
        wait_clk(4);
        check({tag, ".nvalid"}, 32'(n_valid - v0), ev ? 32'd1 : 32'd0);
        if (ev) begin
            check({tag, ".speed"},  32'(speed_code),   32'(code));
            check({tag, ".high"},   32'(high_ticks),   32'(hi));
            check({tag, ".period"}, 32'(period_ticks), 32'(per));
            check({tag, ".rerr"},   32'(range_err),    32'(rerr));
            check({tag, ".perr"},   32'(period_err),   32'(perr));
        end
    endtask

    // Rest of a period whose rising edge close_chk already drove.
    task automatic drive(input int unsigned hi, input int unsigned per);
        wait_clk(hi * TCLK - 4);
        pwm_in = 1'b0;
        wait_clk((per - hi) * TCLK);
    endtask

    initial begin
        int v0;

        wait_clk(4);
        check_zero("rst_held");
        rst_n = 1'b1;
        wait_clk(128);
        check_zero("rst_rel");

        // Arming rise, then two nominal code-0 periods
        close_chk("t1_arm", 1'b0, 0, 0, 0, 0, 0);
        drive(500, 2801);
        close_chk("t1_p1", 1'b1, 0, 500, 2801, 0, 0);
        drive(500, 2801);
        close_chk("t1_p2", 1'b1, 0, 500, 2801, 0, 0);

        drive(2500, 2801);
        close_chk("t2_h2500", 1'b1, 7, 2500, 2801, 0, 0);
        drive(1250, 2801);
        close_chk("t2_h1250", 1'b1, 3, 1250, 2801, 0, 0);
        drive(1249, 2801);
        close_chk("t2_h1249", 1'b1, 2, 1249, 2801, 0, 0);

        drive(300, 2801);
        close_chk("t3_h300", 1'b1, 2, 300, 2801, 1, 0);
        drive(800, 2801);
        close_chk("t3_h800", 1'b1, 1, 800, 2801, 0, 0);

        drive(1100, 2000);
        close_chk("t4_p2000", 1'b1, 2, 1100, 2000, 0, 1);
        drive(1100, 2801);
        close_chk("t4_p2801", 1'b1, 2, 1100, 2801, 0, 0);

        // Line held high: stall declared once per_cnt hits the timeout
        v0 = n_valid;
        wait_clk(4000 * TCLK - 4);
        check("t5_pre.stalled", 32'(stalled), 0);
        wait_clk(1000 * TCLK);
        check("t5_hi.stalled", 32'(stalled), 1);
        check("t5_hi.level", 32'(pwm_level), 1);
        check("t5_hi.nvalid", 32'(n_valid - v0), 0);
        pwm_in = 1'b0;
        wait_clk(300 * TCLK);
        check("t5_lo.stalled", 32'(stalled), 1);
        check("t5_lo.level", 32'(pwm_level), 0);
        close_chk("t5_rearm", 1'b0, 0, 0, 0, 0, 0);
        check("t5_rearm.stalled", 32'(stalled), 0);
        drive(800, 2801);
        close_chk("t5_p", 1'b1, 1, 800, 2801, 0, 0);

        // Reset in the middle of a high phase
        wait_clk(100 * TCLK);
        rst_n = 1'b0;
        wait_clk(1);
        check_zero("t6_in_rst");
        wait_clk(1);
        pwm_in = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        v0 = n_valid;
        wait_clk(128);
        check_zero("t6_rel");
        wait_clk(200 * TCLK);
        close_chk("t6_arm", 1'b0, 0, 0, 0, 0, 0);
        check("t6_arm.total_nvalid", 32'(n_valid - v0), 0);
        check("t6_arm.speed", 32'(speed_code), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
